issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- In-order dual-issue stage directly upstream of the register-read stage.
- Buffers decoded instructions in a small FIFO and tracks pending GPR writes in a 32-entry busy scoreboard.
- Each cycle it issues up to two head instructions, free of RAW/WAW hazards, into the eu0/eu1 slot registers consumed by register read.
- Busy bits are cleared by the same two writeback ports that write the register file.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 4.
- INST_W, 3+`WIDTH_UOP+15+64+6+32, packed instruction width. Layout MSB to LSB: {wr_rd, use_rj, use_rk, uop, rd[4:0], rj[4:0], rk[4:0], pc[31:0], pc_next[31:0], exp[5:0], imm[31:0]}.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dec_valid  in  2  bit0 = dec_inst0 valid, bit1 = dec_inst1 valid; bit1 set only with bit0
- dec_inst0  in  INST_W  older decoded instruction
- dec_inst1  in  INST_W  younger decoded instruction
- dec_ready  out  1  FIFO has >= 2 free entries (combinational from count)
- flush  in  1  pipeline flush (branch mispredict / exception)
- stall_in  in  1  register read / exe cannot accept new slots
- write_en_0, write_en_1  in  1  writeback enables
- write_addr_0, write_addr_1  in  5  writeback register numbers
- eu0_en_out  out  1  eu0 slot valid
- eu0_inst_out  out  INST_W  eu0 instruction
- eu1_en_out  out  1  eu1 slot valid
- eu1_inst_out  out  INST_W  eu1 instruction

Behaviour:
- Reset: FIFO empty, count=0, all busy bits 0, eu0/eu1_en_out=0, eu*_inst_out=0.
- Push:
  - A push happens when dec_ready && dec_valid[0] && !flush.
  - inst0 is written at tail, then inst1 at tail+1 if dec_valid[1].
  - Pointers wrap mod DEPTH.
- Hazard for entry e, with busy_eff[0] always 0:
  - RAW: (use_rj && busy_eff[rj]) || (use_rk && busy_eff[rk]).
  - WAW: wr_rd && rd!=0 && busy_eff[rd].
- Issue h0 (head): count>=1 && !stall_in && !flush && no hazard.
- Issue h1 (head+1): h0 issues && count>=2 && no hazard.
  - h1 is also blocked if h0.wr_rd && h0.rd!=0 && h1 reads h0.rd (rj or rk, with the use bit set) or h1.wr_rd && h1.rd==h0.rd.
- Slot registers, updated at the edge when !stall_in:
  - eu0_en_out=issue_h0, eu0_inst_out=h0 (data held when en=0).
  - eu1_en_out=issue_h1, eu1_inst_out=h1.
  - When stall_in=1, both slots hold their value.
- Latency:
  - Instruction pushed at edge N is eligible in cycle N+1; en_out is high after edge N+1 at the earliest.
- Pop: count decreases by issued count (0/1/2). The same-cycle push is added, and count never exceeds DEPTH.
- Scoreboard:
  - At each edge, write_en_k clears busy[write_addr_k] (addr 0 ignored).
  - Each issued instruction with wr_rd && rd!=0 sets busy[rd].
  - Set beats clear on the same register in the same edge.
  - stall_in does not block clears.
- Flush (priority over stall_in and push):
  - FIFO emptied, count=0, busy all 0, eu0/eu1_en_out=0 at the next edge.
  - dec_ready follows count (high after the flush edge).
- Empty: no issue, en_out=0 unless stall_in holds. Full: dec_ready=0, push ignored.
- rst mid-operation: same result as flush, plus slot data cleared.

Optional Feature:
- Macro: ISSUE_WB_WAKEUP_EN.
- Defined: busy_eff[r] = busy[r] && !((write_en_0 && write_addr_0==r) || (write_en_1 && write_addr_1==r)). A consumer issues in the same cycle its producer writes back; register read forwards the write data.
- Undefined: busy_eff = busy; consumer issues one cycle after the writeback edge.

Test Plan:
- Reset, then push add r1,r2,r3 / add r4,r5,r6 (wr_rd=1, independent) -> one cycle later eu0_en_out=eu1_en_out=1, busy[1]=busy[4]=1, count=0.
- Pair add r1,.. / add r2,r1,r3 -> eu0 issues alone; eu1_en_out=0; younger stays at head until write_en_0=1, addr 1. It issues in the writeback cycle (EN defined) or the cycle after (undefined).
- Push 8 entries with stall_in=1 -> dec_ready=0 at count>=7, the 9th push is ignored, slots unchanged; release stall -> two issued per cycle in program order.
- Writer to r0 (rd=0, wr_rd=1) followed by a reader of r0 -> busy[0] stays 0, both issue as a pair.
- Outstanding busy[5], FIFO count=3, flush=1 with stall_in=1 and dec_valid=2'b11 -> next edge count=0, busy=0, en_out=0, pushes discarded.
- write_en_0 addr 7 in the same edge as issuing a new writer of r7 (WB_WAKEUP_EN defined) -> busy[7]=1 after the edge.

Source files
------------

// File: rtl/issue_scoreboard.sv
// In-order dual-issue stage: decoded-instruction FIFO plus a 32-entry GPR busy scoreboard.
// Define ISSUE_WB_WAKEUP_EN to let consumers issue in their producer's writeback cycle.
`ifndef WIDTH_UOP
`define WIDTH_UOP 8
`endif

module issue_hazard_chk (
  input  logic        wr_rd,
  input  logic        use_rj,
  input  logic        use_rk,
  input  logic [4:0]  rd,
  input  logic [4:0]  rj,
  input  logic [4:0]  rk,
  input  logic [31:0] busy_eff,
  output logic        hazard
);
  assign hazard = (use_rj && busy_eff[rj]) || (use_rk && busy_eff[rk]) ||
                  (wr_rd && (rd != 5'd0) && busy_eff[rd]);
endmodule

module issue_scoreboard #(
  parameter int DEPTH  = 8,
  parameter int INST_W = 3 + `WIDTH_UOP + 15 + 64 + 6 + 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        dec_valid,
  input  logic [INST_W-1:0] dec_inst0,
  input  logic [INST_W-1:0] dec_inst1,
  output logic              dec_ready,
  input  logic              flush,
  input  logic              stall_in,
  input  logic              write_en_0,
  input  logic              write_en_1,
  input  logic [4:0]        write_addr_0,
  input  logic [4:0]        write_addr_1,
  output logic              eu0_en_out,
  output logic [INST_W-1:0] eu0_inst_out,
  output logic              eu1_en_out,
  output logic [INST_W-1:0] eu1_inst_out
);
  localparam int AW     = $clog2(DEPTH);
  localparam int RK_LSB = 102;
  localparam int RJ_LSB = 107;
  localparam int RD_LSB = 112;

  logic [INST_W-1:0] fifo [DEPTH];
  logic [AW-1:0]     head, tail;
  logic [AW:0]       count;
  logic [31:0]       busy, busy_eff, wb_clr, wr_set;

  logic [1:0][INST_W-1:0] lane_inst;
  logic [1:0][4:0]        lane_rd, lane_rj, lane_rk;
  logic [1:0]             lane_wr, lane_uj, lane_uk, lane_haz;

  logic       push, issue_h0, issue_h1, h1_dep;
  logic [1:0] n_push, n_issue;

  assign dec_ready = (count <= (AW+1)'(DEPTH - 2));
  assign push      = dec_ready && dec_valid[0] && !flush;
  assign n_push    = push ? (dec_valid[1] ? 2'd2 : 2'd1) : 2'd0;

  assign lane_inst[0] = fifo[head];
  assign lane_inst[1] = fifo[head + AW'(1)];

  always_comb begin
    wb_clr = '0;
    if (write_en_0) wb_clr[write_addr_0] = 1'b1;
    if (write_en_1) wb_clr[write_addr_1] = 1'b1;
    wb_clr[0] = 1'b0;
`ifdef ISSUE_WB_WAKEUP_EN
    busy_eff = busy & ~wb_clr;
`else
    busy_eff = busy;
`endif
    busy_eff[0] = 1'b0;
  end

  for (genvar i = 0; i < 2; i++) begin : g_lane
    assign lane_wr[i] = lane_inst[i][INST_W-1];
    assign lane_uj[i] = lane_inst[i][INST_W-2];
    assign lane_uk[i] = lane_inst[i][INST_W-3];
    assign lane_rd[i] = lane_inst[i][RD_LSB +: 5];
    assign lane_rj[i] = lane_inst[i][RJ_LSB +: 5];
    assign lane_rk[i] = lane_inst[i][RK_LSB +: 5];
    issue_hazard_chk u_chk (
      .wr_rd   (lane_wr[i]),
      .use_rj  (lane_uj[i]),
      .use_rk  (lane_uk[i]),
      .rd      (lane_rd[i]),
      .rj      (lane_rj[i]),
      .rk      (lane_rk[i]),
      .busy_eff(busy_eff),
      .hazard  (lane_haz[i])
    );
  end

  // Younger head may not consume or overwrite the older head's destination in the same cycle.
  assign h1_dep = lane_wr[0] && (lane_rd[0] != 5'd0) &&
                  ((lane_uj[1] && lane_rj[1] == lane_rd[0]) ||
                   (lane_uk[1] && lane_rk[1] == lane_rd[0]) ||
                   (lane_wr[1] && lane_rd[1] == lane_rd[0]));

  assign issue_h0 = (count >= (AW+1)'(1)) && !stall_in && !flush && !lane_haz[0];
  assign issue_h1 = issue_h0 && (count >= (AW+1)'(2)) && !lane_haz[1] && !h1_dep;
  assign n_issue  = {1'b0, issue_h0} + {1'b0, issue_h1};

  always_comb begin
    wr_set = '0;
    if (issue_h0 && lane_wr[0]) wr_set[lane_rd[0]] = 1'b1;
    if (issue_h1 && lane_wr[1]) wr_set[lane_rd[1]] = 1'b1;
    wr_set[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      busy         <= '0;
      eu0_en_out   <= 1'b0;
      eu1_en_out   <= 1'b0;
      eu0_inst_out <= '0;
      eu1_inst_out <= '0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      busy       <= '0;
      eu0_en_out <= 1'b0;
      eu1_en_out <= 1'b0;
    end else begin
      if (push) begin
        fifo[tail] <= dec_inst0;
        if (dec_valid[1]) fifo[tail + AW'(1)] <= dec_inst1;
      end
      tail  <= tail + AW'(n_push);
      head  <= head + AW'(n_issue);
      count <= count + (AW+1)'(n_push) - (AW+1)'(n_issue);
      busy  <= (busy & ~wb_clr) | wr_set;
      if (!stall_in) begin
        eu0_en_out <= issue_h0;
        eu1_en_out <= issue_h1;
        if (issue_h0) eu0_inst_out <= lane_inst[0];
        if (issue_h1) eu1_inst_out <= lane_inst[1];
      end
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// Random + directed bench for issue_scoreboard against a queue-based reference model.
`ifndef WIDTH_UOP
`define WIDTH_UOP 8
`endif

module tb_issue_scoreboard;
  localparam int DEPTH  = 8;
  localparam int UW     = `WIDTH_UOP;
  localparam int INST_W = 120 + UW;
`ifdef ISSUE_WB_WAKEUP_EN
  localparam bit WAKE = 1'b1;
`else
  localparam bit WAKE = 1'b0;
`endif
  typedef logic [INST_W-1:0] inst_t;

  logic clk = 1'b0;
  logic rst, flush, stall_in, write_en_0, write_en_1, dec_ready;
  logic [1:0] dec_valid;
  inst_t dec_inst0, dec_inst1, eu0_inst_out, eu1_inst_out;
  logic [4:0] write_addr_0, write_addr_1;
  logic eu0_en_out, eu1_en_out;

  issue_scoreboard #(.DEPTH(DEPTH), .INST_W(INST_W)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_inst0(dec_inst0),
    .dec_inst1(dec_inst1), .dec_ready(dec_ready), .flush(flush), .stall_in(stall_in),
    .write_en_0(write_en_0), .write_en_1(write_en_1), .write_addr_0(write_addr_0),
    .write_addr_1(write_addr_1), .eu0_en_out(eu0_en_out), .eu0_inst_out(eu0_inst_out),
    .eu1_en_out(eu1_en_out), .eu1_inst_out(eu1_inst_out)
  );

  always #5 clk = ~clk;

  // reference model state
  inst_t       q[$];
  logic [31:0] m_busy;
  bit          m_en0, m_en1;
  inst_t       m_i0, m_i1;
  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input inst_t got, input inst_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit f_wr(inst_t x); return x[INST_W-1]; endfunction
  function automatic bit f_uj(inst_t x); return x[INST_W-2]; endfunction
  function automatic bit f_uk(inst_t x); return x[INST_W-3]; endfunction
  function automatic logic [4:0] f_rd(inst_t x); return x[116:112]; endfunction
  function automatic logic [4:0] f_rj(inst_t x); return x[111:107]; endfunction
  function automatic logic [4:0] f_rk(inst_t x); return x[106:102]; endfunction

  function automatic inst_t mk(bit wr, bit uj, bit uk, logic [4:0] rd, logic [4:0] rj, logic [4:0] rk);
    logic [UW-1:0] uop;
    uop = UW'($urandom);
    return {wr, uj, uk, uop, rd, rj, rk, 32'($urandom), 32'($urandom), 6'($urandom), 32'($urandom)};
  endfunction

  function automatic bit haz(inst_t e, logic [31:0] be);
    return (f_uj(e) && be[f_rj(e)]) || (f_uk(e) && be[f_rk(e)]) ||
           (f_wr(e) && f_rd(e) != 0 && be[f_rd(e)]);
  endfunction

  function automatic bit dep(inst_t o, inst_t y);
    if (!(f_wr(o) && f_rd(o) != 0)) return 1'b0;
    return (f_uj(y) && f_rj(y) == f_rd(o)) || (f_uk(y) && f_rk(y) == f_rd(o)) ||
           (f_wr(y) && f_rd(y) == f_rd(o));
  endfunction

  task automatic step(input bit rs, input bit fl, input bit st, input logic [1:0] dv,
                      input inst_t a, input inst_t b, input bit we0, input logic [4:0] wa0,
                      input bit we1, input logic [4:0] wa1);
    logic [31:0] clr, beff;
    bit i0, i1, rdy;
    inst_t h0, h1;
    @(negedge clk);
    rst = rs; flush = fl; stall_in = st; dec_valid = dv; dec_inst0 = a; dec_inst1 = b;
    write_en_0 = we0; write_addr_0 = wa0; write_en_1 = we1; write_addr_1 = wa1;
    #1;
    rdy = (DEPTH - q.size()) >= 2;
    chk("dec_ready", inst_t'(dec_ready), inst_t'(rdy));
    clr = '0;
    for (int r = 1; r < 32; r++)
      clr[r] = (we0 && wa0 == r) || (we1 && wa1 == r);
    beff = WAKE ? (m_busy & ~clr) : m_busy;
    beff[0] = 1'b0;
    h0 = (q.size() > 0) ? q[0] : '0;
    h1 = (q.size() > 1) ? q[1] : '0;
    i0 = q.size() >= 1 && !st && !fl && !haz(h0, beff);
    i1 = i0 && q.size() >= 2 && !haz(h1, beff) && !dep(h0, h1);
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete(); m_busy = '0; m_en0 = 0; m_en1 = 0; m_i0 = '0; m_i1 = '0;
    end else if (fl) begin
      q.delete(); m_busy = '0; m_en0 = 0; m_en1 = 0;
    end else begin
      m_busy = m_busy & ~clr;
      if (i0 && f_wr(h0) && f_rd(h0) != 0) m_busy[f_rd(h0)] = 1'b1;
      if (i1 && f_wr(h1) && f_rd(h1) != 0) m_busy[f_rd(h1)] = 1'b1;
      if (!st) begin
        m_en0 = i0; m_en1 = i1;
        if (i0) m_i0 = h0;
        if (i1) m_i1 = h1;
      end
      if (i0) void'(q.pop_front());
      if (i1) void'(q.pop_front());
      if (rdy && dv[0]) begin
        q.push_back(a);
        if (dv[1]) q.push_back(b);
      end
    end
    chk("eu0_en", inst_t'(eu0_en_out), inst_t'(m_en0));
    chk("eu1_en", inst_t'(eu1_en_out), inst_t'(m_en1));
    chk("eu0_inst", eu0_inst_out, m_i0);
    chk("eu1_inst", eu1_inst_out, m_i1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 2'b00, '0, '0, 0, 5'd0, 0, 5'd0);
  endtask

  task automatic push2(input bit st, input inst_t a, input inst_t b);
    step(0, 0, st, 2'b11, a, b, 0, 5'd0, 0, 5'd0);
  endtask

  task automatic wb(input logic [4:0] r0, input logic [4:0] r1);
    step(0, 0, 0, 2'b00, '0, '0, 1, r0, 1, r1);
  endtask

  initial begin
    rst = 1; flush = 0; stall_in = 0; dec_valid = 0; dec_inst0 = '0; dec_inst1 = '0;
    write_en_0 = 0; write_en_1 = 0; write_addr_0 = 0; write_addr_1 = 0;
    q.delete(); m_busy = '0; m_en0 = 0; m_en1 = 0; m_i0 = '0; m_i1 = '0;
    step(1, 0, 0, 2'b00, '0, '0, 0, 5'd0, 0, 5'd0);
    step(1, 0, 0, 2'b00, '0, '0, 0, 5'd0, 0, 5'd0);

    // independent pair dual-issues
    push2(0, mk(1, 1, 1, 5'd1, 5'd2, 5'd3), mk(1, 1, 1, 5'd4, 5'd5, 5'd6));
    idle(2);
    wb(5'd1, 5'd4);
    // RAW inside the pair: younger waits for writeback of r1
    push2(0, mk(1, 1, 1, 5'd1, 5'd2, 5'd3), mk(1, 1, 1, 5'd2, 5'd1, 5'd3));
    idle(3);
    step(0, 0, 0, 2'b00, '0, '0, 1, 5'd1, 0, 5'd0);
    idle(2);
    wb(5'd2, 5'd1);
    // fill under stall, ninth entry ignored, then drain
    for (int i = 0; i < 5; i++)
      push2(1, mk(1, 0, 0, 5'(8 + 2*i), 5'd0, 5'd0), mk(1, 0, 0, 5'(9 + 2*i), 5'd0, 5'd0));
    idle(6);
    for (int i = 0; i < 5; i++) wb(5'(8 + 2*i), 5'(9 + 2*i));
    // r0 writer never blocks
    push2(0, mk(1, 0, 0, 5'd0, 5'd0, 5'd0), mk(1, 1, 1, 5'd3, 5'd0, 5'd0));
    idle(2);
    wb(5'd3, 5'd0);
    // flush under stall with pending busy and incoming pair
    step(0, 0, 0, 2'b01, mk(1, 0, 0, 5'd5, 5'd0, 5'd0), '0, 0, 5'd0, 0, 5'd0);
    idle(1);
    push2(1, mk(1, 1, 0, 5'd6, 5'd5, 5'd0), mk(0, 1, 1, 5'd0, 5'd6, 5'd5));
    step(0, 0, 1, 2'b01, mk(1, 0, 0, 5'd9, 5'd1, 5'd2), '0, 0, 5'd0, 0, 5'd0);
    step(0, 1, 1, 2'b11, mk(1, 0, 0, 5'd1, 5'd0, 5'd0), mk(1, 0, 0, 5'd2, 5'd0, 5'd0), 0, 5'd0, 0, 5'd0);
    push2(0, mk(0, 1, 1, 5'd0, 5'd5, 5'd5), mk(0, 1, 0, 5'd0, 5'd5, 5'd0));
    idle(2);
    // writeback of r7 coincides with a new r7 writer reaching the head
    step(0, 0, 0, 2'b01, mk(1, 0, 0, 5'd7, 5'd0, 5'd0), '0, 0, 5'd0, 0, 5'd0);
    idle(1);
    step(0, 0, 0, 2'b01, mk(1, 0, 0, 5'd7, 5'd0, 5'd0), '0, 0, 5'd0, 0, 5'd0);
    step(0, 0, 0, 2'b00, '0, '0, 1, 5'd7, 0, 5'd0);
    idle(2);
    wb(5'd7, 5'd0);
    idle(2);
    wb(5'd7, 5'd0);

    // randomized traffic with small register range for frequent hazards
    for (int n = 0; n < 3000; n++) begin
      int c;
      logic [1:0] dv;
      c = $urandom % 4;
      dv = (c == 0) ? 2'b00 : (c == 1) ? 2'b01 : 2'b11;
      step(($urandom % 200) == 0, ($urandom % 30) == 0, ($urandom % 4) == 0, dv,
           mk(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8)),
           mk(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8)),
           1'($urandom), 5'($urandom % 8), 1'($urandom), 5'($urandom % 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
